// File: rtl/pc_pkg.sv
// Shared types and constants for the PC / fetch-sequencing stage.
package pc_pkg;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP_DEFAULT  = 32'd4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  // Clear the byte-offset bits so a redirect always lands on a word boundary.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select: jump beats branch beats sequential advance beats hold.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              redirect_en,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc_next_c,
  output logic              redirect_c,
  output logic              misalign_c
);

  logic [ADDR_W-1:0] target_raw;

  // Prioritised target pick, alignment masking and misalignment detect.
  always_comb begin
    target_raw = jmp ? jmp_target : br_target;
    redirect_c = redirect_en & (jmp | br_taken);
    misalign_c = redirect_c & (target_raw[1:0] != 2'b00);
    if (redirect_c) begin
      pc_next_c = align_word(target_raw);
    end else if (advance) begin
      pc_next_c = ADDR_W'(pc + PC_STEP);
    end else begin
      pc_next_c = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer feeding the IF/ID PC buffer.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              misalign_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              pc_valid_q, pc_valid_d;
  logic              req_q, req_d;
  logic              err_q, err_d;

  logic              fetch_ack_c;
  logic              redirect_en_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic              redirect_c;
  logic              misalign_c;

  // An ack only counts while a request is actually on the bus.
  assign fetch_ack_c   = (state_q == REQ) & imem_ack;
  // Redirects are ignored during the single boot cycle.
  assign redirect_en_c = (state_q != BOOT);

  pc_next_mux #(
    .PC_STEP (PC_STEP)
  ) u_next (
    .pc          (pc_q),
    .advance     (fetch_ack_c),
    .redirect_en (redirect_en_c),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc_next_c   (pc_next_c),
    .redirect_c  (redirect_c),
    .misalign_c  (misalign_c)
  );

  // Next-state and next-output decode. The state follows stall alone; a
  // redirect only changes the PC, and it squashes a same-cycle delivery.
  always_comb begin
    state_d    = state_q;
    pc_out_d   = pc_out_q;
    pc_valid_d = 1'b0;
    err_d      = err_q | misalign_c;

    unique case (state_q)
      BOOT: begin
        state_d = stall ? STALL : REQ;
      end
      REQ: begin
        state_d = stall ? STALL : REQ;
        if (imem_ack && !redirect_c) begin
          pc_valid_d = 1'b1;
          pc_out_d   = pc_q;
        end
      end
      STALL: begin
        state_d = stall ? STALL : REQ;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    req_d = (state_d == REQ);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      pc_valid_q <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_next_c;
      pc_out_q   <= pc_out_d;
      pc_valid_q <= pc_valid_d;
      req_q      <= req_d;
      err_q      <= err_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc_out       = pc_out_q;
  assign pc_valid     = pc_valid_q;
  assign misalign_err = err_q;

endmodule
